// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store memory access controller:
// operation codes, FSM state type, timeout default and lane helpers.
package mem_ctrl_pkg;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] LB      = 4'b0001;
  localparam logic [3:0] LH      = 4'b0010;
  localparam logic [3:0] LW      = 4'b1000;
  localparam logic [3:0] LBU     = 4'b1001;
  localparam logic [3:0] LHU     = 4'b1010;
  localparam logic [3:0] SB      = 4'b0001;
  localparam logic [3:0] SH      = 4'b0010;
  localparam logic [3:0] SW      = 4'b1000;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  function automatic logic is_load(input logic [3:0] code);
    return (code == LB) || (code == LH) || (code == LW) || (code == LBU) || (code == LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] code);
    return (code == SB) || (code == SH) || (code == SW);
  endfunction

  // Access size is encoded in code[1:0]: 01 byte, 10 half, 00 word.
  function automatic logic misaligned(input logic [3:0] code, input logic [1:0] lane);
    return ((code[1:0] == 2'b10) && lane[0]) || ((code[1:0] == 2'b00) && (lane != 2'b00));
  endfunction

  function automatic logic [3:0] byte_en(input logic [3:0] code, input logic [1:0] lane);
    case (code[1:0])
      2'b01:   return 4'b0001 << lane;
      2'b10:   return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [3:0] code, input logic [31:0] data);
    case (code[1:0])
      2'b01:   return {4{data[7:0]}};
      2'b10:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load lane extraction: shifts the addressed byte/half down
// to bit 0 and applies sign or zero extension according to the load code.
module load_aligner
  import mem_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = word >> {lane, 3'b000};

  always_comb begin
    data = '0;
    case (op)
      LB:      data = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     data = {24'b0, shifted[7:0]};
      LH:      data = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     data = {16'b0, shifted[15:0]};
      LW:      data = shifted;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit bus controller: IDLE -> BUS -> DONE handshake with a
// bus-ack timeout, misalignment detection and aligned load return data.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  mem_read_i,
  input  logic [3:0]  mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  state_t      state;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic        load_q;
  logic [7:0]  cnt;

  logic        ld_ok;
  logic        st_ok;
  logic [3:0]  sel_code;
  logic        op_valid;
  logic        op_misal;
  logic        go;
  logic        timeout_hit;
  logic [31:0] aligned;

  // A valid read always shadows a simultaneous write.
  assign ld_ok       = is_load(mem_read_i);
  assign st_ok       = !ld_ok && is_store(mem_write_i);
  assign sel_code    = ld_ok ? mem_read_i : mem_write_i;
  assign op_valid    = ld_ok || st_ok;
  assign op_misal    = misaligned(sel_code, addr_i[1:0]);
  assign go          = (state == IDLE) && op_valid && !op_misal;
  assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

  assign stall_o = (state == BUS) || go;

  load_aligner u_load_aligner (
    .op   (op_q),
    .lane (lane_q),
    .word (bus_rdata_i),
    .data (aligned)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      op_q          <= OP_NONE;
      lane_q        <= '0;
      load_q        <= 1'b0;
      cnt           <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      bus_err_o     <= 1'b0;
      bus_req_o     <= 1'b0;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= '0;
      bus_be_o      <= '0;
      bus_wdata_o   <= '0;
    end else begin
      rdata_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      bus_err_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid && op_misal) begin
            misalign_o <= 1'b1;
          end else if (go) begin
            op_q        <= sel_code;
            lane_q      <= addr_i[1:0];
            load_q      <= ld_ok;
            cnt         <= '0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= st_ok;
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_be_o    <= byte_en(sel_code, addr_i[1:0]);
            bus_wdata_o <= st_ok ? lane_data(sel_code, wdata_i) : '0;
            state       <= BUS;
          end
        end
        BUS: begin
          if (bus_ack_i || timeout_hit) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            state       <= DONE;
            // Ack takes priority over a coincident timeout.
            if (bus_ack_i) begin
              if (load_q) begin
                rdata_o       <= aligned;
                rdata_valid_o <= 1'b1;
              end
            end else begin
              bus_err_o <= 1'b1;
              rdata_o   <= '0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed ops push expected bus and
// completion events; a monitor pops and compares as the DUT reports them.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int K_BUS = 0;
  localparam int K_RD  = 1;
  localparam int K_ERR = 2;
  localparam int K_MIS = 3;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } ev_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  mem_read_i;
  logic [3:0]  mem_write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_req = 1'b0;

  always #5 clk_i = ~clk_i;

  mem_access_ctrl dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .mem_read_i    (mem_read_i),
    .mem_write_i   (mem_write_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .misalign_o    (misalign_o),
    .bus_err_o     (bus_err_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_be_o      (bus_be_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_ack_i     (bus_ack_i),
    .bus_rdata_i   (bus_rdata_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void exp_ev(input int k, input logic [31:0] a, b, c, d);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c; e.d = d;
    exp_q.push_back(e);
  endfunction

  task automatic seen(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d want none", k);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      if (k == e.kind) begin
        case (k)
          K_BUS: begin
            chk("bus_we", {31'b0, bus_we_o}, e.a);
            chk("bus_addr", bus_addr_o, e.b);
            chk("bus_be", {28'b0, bus_be_o}, e.c);
            chk("bus_wdata", bus_wdata_o, e.d);
          end
          K_RD:  chk("rdata", rdata_o, e.a);
          K_ERR: begin
            chk("err_rdata", rdata_o, 32'h0);
            chk("err_rdata_valid", {31'b0, rdata_valid_o}, 32'h0);
          end
          default: ;
        endcase
      end
    end
  endtask

  // Monitor: every reported event must match the head of the expectation queue.
  initial begin
    forever begin
      @(negedge clk_i);
      if (bus_req_o && !prev_req) seen(K_BUS);
      if (rdata_valid_o) seen(K_RD);
      if (bus_err_o) seen(K_ERR);
      if (misalign_o) seen(K_MIS);
      prev_req = bus_req_o;
    end
  end

  task automatic run_op(input logic [3:0] rd, input logic [3:0] wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat, input int ack_at,
                        input logic rel, output int stall_cnt, output int bus_cyc);
    int guard;
    @(negedge clk_i);
    if (rel) rst_n_i = 1'b1;
    mem_read_i = rd; mem_write_i = wr; addr_i = a; wdata_i = wd;
    #1;
    stall_cnt = stall_o ? 1 : 0;
    bus_cyc = 0;
    @(negedge clk_i);
    mem_read_i = '0; mem_write_i = '0; addr_i = '0; wdata_i = '0;
    #1;
    guard = 0;
    while (stall_o && guard < 400) begin
      stall_cnt++;
      bus_cyc++;
      guard++;
      if (bus_cyc == ack_at) begin
        bus_ack_i = 1'b1;
        bus_rdata_i = rdat;
      end
      @(negedge clk_i);
      bus_ack_i = 1'b0;
      bus_rdata_i = '0;
      #1;
    end
    if (guard >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stall_release: got stuck after %0d cycles want release", guard);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, bc;
    rst_n_i = 1'b0;
    mem_read_i = '0; mem_write_i = '0; addr_i = '0; wdata_i = '0;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    #12;
    chk("rst_stall", {31'b0, stall_o}, 0);
    chk("rst_bus_req", {31'b0, bus_req_o}, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_flags", {29'b0, rdata_valid_o, misalign_o, bus_err_o}, 0);
    chk("rst_be", {28'b0, bus_be_o}, 0);

    // LB sign-extended from the top byte, ack on second BUS cycle
    exp_ev(K_BUS, 0, 32'h1000, 4'b1000, 0);
    exp_ev(K_RD, 32'hFFFFFF80, 0, 0, 0);
    run_op(LB, OP_NONE, 32'h1003, 0, 32'h80FFFFFF, 2, 1'b1, st, bc);
    chk("lb_stall_cycles", st, 3);

    // SH upper half: replicated lanes, no read completion
    exp_ev(K_BUS, 1, 32'h2000, 4'b1100, 32'hABCDABCD);
    run_op(OP_NONE, SH, 32'h2002, 32'h1234ABCD, 0, 1, 1'b0, st, bc);
    chk("sh_stall_cycles", st, 2);
    chk("rdata_hold_after_store", rdata_o, 32'hFFFFFF80);

    // LW misaligned: pulse only, no bus, no stall
    exp_ev(K_MIS, 0, 0, 0, 0);
    run_op(LW, OP_NONE, 32'h0006, 0, 0, 1, 1'b0, st, bc);
    chk("lw_misal_stall", st, 0);

    // LHU with no ack: timeout after 255 BUS cycles
    exp_ev(K_BUS, 0, 32'h0000, 4'b1100, 0);
    exp_ev(K_ERR, 0, 0, 0, 0);
    run_op(LHU, OP_NONE, 32'h0002, 0, 0, 0, 1'b0, st, bc);
    chk("timeout_bus_cycles", bc, 255);
    chk("timeout_bus_req", {31'b0, bus_req_o}, 0);

    // Read and write together: read wins; ack coincides with timeout
    exp_ev(K_BUS, 0, 32'h0040, 4'b1111, 0);
    exp_ev(K_RD, 32'h11223344, 0, 0, 0);
    run_op(LW, SW, 32'h0040, 32'hDEADBEEF, 32'h11223344, 255, 1'b0, st, bc);
    chk("ack_vs_timeout_cycles", bc, 255);

    // LH from upper half, sign-extended
    exp_ev(K_BUS, 0, 32'h0100, 4'b1100, 0);
    exp_ev(K_RD, 32'hFFFF8001, 0, 0, 0);
    run_op(LH, OP_NONE, 32'h0102, 0, 32'h80010000, 1, 1'b0, st, bc);

    // LBU from lane 1, zero-extended
    exp_ev(K_BUS, 0, 32'h0100, 4'b0010, 0);
    exp_ev(K_RD, 32'h000000F5, 0, 0, 0);
    run_op(LBU, OP_NONE, 32'h0101, 0, 32'h0000F500, 1, 1'b0, st, bc);

    // SB lane 3
    exp_ev(K_BUS, 1, 32'h0000, 4'b1000, 32'hABABABAB);
    run_op(OP_NONE, SB, 32'h0003, 32'h000000AB, 0, 1, 1'b0, st, bc);

    // Unlisted read code alone: nothing happens
    run_op(4'b0011, OP_NONE, 32'h0000, 0, 0, 1, 1'b0, st, bc);
    chk("unlisted_stall", st, 0);

    // Unlisted read code with a valid SW: store proceeds
    exp_ev(K_BUS, 1, 32'h0020, 4'b1111, 32'h55AA55AA);
    run_op(4'b0100, SW, 32'h0020, 32'h55AA55AA, 0, 1, 1'b0, st, bc);
    chk("unlisted_rd_sw_stall", st, 2);

    // LH misaligned
    exp_ev(K_MIS, 0, 0, 0, 0);
    run_op(LH, OP_NONE, 32'h0001, 0, 0, 1, 1'b0, st, bc);

    // Reset mid-BUS drops the request immediately
    exp_ev(K_BUS, 0, 32'h0080, 4'b1111, 0);
    @(negedge clk_i);
    mem_read_i = LW; addr_i = 32'h0080;
    @(negedge clk_i);
    mem_read_i = '0; addr_i = '0;
    @(negedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("mid_bus_reset_req", {31'b0, bus_req_o}, 0);
    chk("mid_bus_reset_stall", {31'b0, stall_o}, 0);

    // SW accepted in the first cycle after release
    exp_ev(K_BUS, 1, 32'h0010, 4'b1111, 32'hCAFEF00D);
    run_op(OP_NONE, SW, 32'h0010, 32'hCAFEF00D, 0, 1, 1'b1, st, bc);
    chk("post_reset_sw_stall", st, 2);

    repeat (3) @(negedge clk_i);
    #1;
    chk("pending_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk_i  in  1  rising-edge clock.
REQ-003 rst_n_i  in  1  asynchronous active-low reset.
REQ-004 mem_read_i  in  4  load code: 0001 LB, 0010 LH, 1000 LW, 1001 LBU, 1010 LHU, 0000 none.
REQ-005 mem_write_i  in  4  store code: 0001 SB, 0010 SH, 1000 SW, 0000 none.
REQ-006 addr_i  in  32  byte address (ALU result).
REQ-007 wdata_i  in  32  store data (rs2).
REQ-008 stall_o  out  1  pipeline hold request.
REQ-009 rdata_o  out  32  aligned, extended load result.
REQ-010 rdata_valid_o  out  1  one-cycle pulse when rdata_o is valid.
REQ-011 misalign_o  out  1  one-cycle misaligned-access pulse.
REQ-012 bus_err_o  out  1  one-cycle bus-timeout pulse.
REQ-013 bus_req_o, bus_we_o  out  1 each  bus request and write strobe.
REQ-014 bus_addr_o  out  32  word address, with bits [1:0] forced to 00.
REQ-015 bus_be_o  out  4  byte enables.
REQ-016 bus_wdata_o  out  32  lane-replicated store data.
REQ-017 bus_ack_i  in  1  bus completion, accompanied by bus_rdata_i (32 bits).
REQ-018 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles to wait for bus_ack_i.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUS and DONE.
REQ-020 Valid op: any listed nonzero code; unlisted codes SHALL be treated as none.
REQ-021 If both read and write codes are valid, the read SHALL win and the write SHALL be ignored.
REQ-022 Misaligned: halfword with addr_i[0]=1, or word with addr_i[1:0]≠00.
  - In IDLE, a valid misaligned op SHALL pulse misalign_o for one cycle.
  - No bus cycle SHALL be issued and stall_o SHALL stay low.
REQ-023 In IDLE, a valid aligned op SHALL:
  - drive stall_o high combinationally in that same cycle;
  - latch the op, address and data;
  - enter BUS on the next edge.
REQ-024 In BUS:
  - bus_req_o SHALL be 1 and stall_o SHALL be 1.
  - bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o SHALL be driven from latched values and held stable until ack.
REQ-025 Byte enables: byte = 0001 << addr[1:0]; half = 0011 << (2*addr[1]); word = 1111.
REQ-026 Store data lanes: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-027 On bus_ack_i=1 in BUS:
  - loads SHALL capture the extracted lane (byte or half shifted down by 8*addr[1:0]);
  - LBU/LHU SHALL zero-extend, and LB/LH SHALL sign-extend;
  - the FSM SHALL go to DONE.
REQ-028 DONE SHALL last exactly one cycle:
  - stall_o=0 and bus_req_o=0;
  - rdata_valid_o=1 for loads only;
  - return to IDLE;
  - inputs SHALL be ignored in DONE.
REQ-029 rdata_o SHALL hold its last value until the next load completes.
REQ-030 Timeout: an 8-bit counter SHALL clear on BUS entry and increment each BUS cycle without ack.
  - When it reaches TIMEOUT, the block SHALL drop bus_req_o and go to DONE with bus_err_o=1, rdata_valid_o=0, rdata_o=0.
REQ-031 If ack and timeout occur in the same cycle, ack SHALL win.
REQ-032 Minimum latency SHALL be: op cycle, then BUS with ack, then DONE (3 cycles, with stall high for 2).

Reset
REQ-033 On rst_n_i low, the FSM SHALL go to IDLE immediately.
  - All outputs SHALL be 0 and the counter and latches SHALL clear.
  - bus_req_o SHALL drop asynchronously, even mid-BUS.
REQ-034 After reset release, the block SHALL accept a new op in the first cycle.

Structure
REQ-035 Shared package mem_ctrl_pkg SHALL hold the load/store code constants, the state enum and the TIMEOUT default.
REQ-036 Lane extraction and sign/zero extension SHALL be in a combinational sub-module named load_aligner.
REQ-037 Target size is 120–400 RTL lines.

Verification
REQ-038 LB, addr 0x1003, bus_rdata 0x80FFFFFF, ack after 2 cycles -> bus_be 1000, bus_addr 0x1000, rdata_o 0xFFFFFF80, stall high 3 cycles.
REQ-039 SH, addr 0x2002, wdata 0x1234ABCD -> bus_we=1, bus_be 1100, bus_wdata 0xABCDABCD, rdata_valid_o stays 0.
REQ-040 LW, addr 0x0006 -> misalign_o pulses 1 cycle, bus_req_o never asserts, stall_o stays 0.
REQ-041 LHU, addr 0x0002, no ack -> after 255 BUS cycles bus_err_o pulses, bus_req_o drops, stall releases.
REQ-042 rst_n_i low during BUS -> bus_req_o 0 in the same cycle; after release, SW at 0x10 completes normally.
REQ-043 mem_read_i=1000 and mem_write_i=1000 together -> read only (bus_we=0); ack and timeout in the same cycle -> normal completion, no bus_err_o.
